// File: rtl/output_serializer.sv
// MSB-first parallel-to-serial transmitter; each bit is held BIT_CYCLES clocks, with a strobe on its last cycle.
// MSB is driven one cycle after accept; send is accepted only in IDLE, never queued; outputs come straight from flops.
module output_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             send,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] current_shift
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [CCW-1:0] CYC_LAST = CCW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CCW-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic             bit_out_q, bit_valid_q, busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (send) begin
          state_d   = S_SHIFT;
          shift_d   = data_in;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (cyc_cnt_q == CYC_LAST) begin
          shift_d   = shift_q << 1;
          cyc_cnt_d = '0;
          // Bit counter wraps to 0 on the last bit rather than overrunning WIDTH-1.
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = S_DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CCW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      bit_out_q   <= (state_d == S_SHIFT) && shift_d[WIDTH-1];
      bit_valid_q <= (state_d == S_SHIFT) && (cyc_cnt_d == CYC_LAST);
      busy_q      <= (state_d == S_SHIFT);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bit_out       = bit_out_q;
  assign bit_valid     = bit_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign current_shift = shift_q;

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: two instances (BIT_CYCLES 1 and 3) share stimulus and are tracked by a cycle-count model.
module tb_output_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         send = 1'b0;
  logic [W-1:0] data_in = '0;

  logic         bo1, bv1, by1, dn1;
  logic [W-1:0] cs1;
  logic         bo3, bv3, by3, dn3;
  logic [W-1:0] cs3;

  always #5 clk = ~clk;

  output_serializer #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .send(send),
    .bit_out(bo1), .bit_valid(bv1), .busy(by1), .done(dn1), .current_shift(cs1)
  );

  output_serializer #(.WIDTH(W), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .send(send),
    .bit_out(bo3), .bit_valid(bv3), .busy(by3), .done(dn3), .current_shift(cs3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the frame began (-1 = idle); frame occupies k = 0..W*bc-1, done at k = W*bc.
  typedef struct packed {
    logic         bo;
    logic         bv;
    logic         by;
    logic         dn;
    logic [W-1:0] cs;
  } obs_t;

  int           k1 = -1;
  int           k3 = -1;
  logic [W-1:0] w1 = '0;
  logic [W-1:0] w3 = '0;

  function automatic obs_t model_out(input int k, input logic [W-1:0] w, input int bc);
    obs_t e;
    int   b;
    e = '0;
    if (k >= 0 && k < W * bc) begin
      b    = k / bc;
      e.by = 1'b1;
      e.cs = w << b;
      e.bo = w[W-1-b];
      e.bv = ((k % bc) == bc - 1);
    end else if (k == W * bc) begin
      e.dn = 1'b1;
    end
    return e;
  endfunction

  task automatic step(inout int k, inout logic [W-1:0] w, input int bc);
    if (k < 0) begin
      if (send) begin
        k = 0;
        w = data_in;
      end
    end else begin
      k++;
      if (k > W * bc) k = -1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k1 = -1;
      k3 = -1;
    end else begin
      step(k1, w1, 1);
      step(k3, w3, 3);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cycle_bc1", {bo1, bv1, by1, dn1, cs1}, model_out(k1, w1, 1));
      chk("cycle_bc3", {bo3, bv3, by3, dn3, cs3}, model_out(k3, w3, 3));
    end
  end

  typedef struct {
    logic [W-1:0] data;
    bit           ign;
    logic [W-1:0] exp_bits;
    int           exp_done1;
    int           exp_done3;
  } vec_t;

  task automatic run_frame(input vec_t v);
    logic [W-1:0] c1, c3;
    int d1, d3, n1, n3;
    c1 = '0; c3 = '0; d1 = -1; d3 = -1; n1 = 0; n3 = 0;
    @(negedge clk);
    #2 send = 1'b1; data_in = v.data;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bv1) c1 = {c1[W-2:0], bo1};
      if (bv3) c3 = {c3[W-2:0], bo3};
      if (dn1) begin n1++; if (d1 < 0) d1 = c; end
      if (dn3) begin n3++; if (d3 < 0) d3 = c; end
      #2;
      if (v.ign && c >= 2 && c <= 7) begin
        send    = c[0];
        data_in = 8'hFF;
      end else begin
        send = 1'b0;
      end
    end
    chk("frame_bits_bc1", c1, v.exp_bits);
    chk("frame_bits_bc3", c3, v.exp_bits);
    chk("done_cycle_bc1", d1, v.exp_done1);
    chk("done_cycle_bc3", d3, v.exp_done3);
    chk("done_pulses", n1 + n3, 2);
  endtask

  vec_t vecs[6];

  initial begin
    int dcnt, dfirst, dsecond;
    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 9, 25};
    vecs[1] = '{8'h81, 1'b0, 8'h81, 9, 25};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 9, 25};
    vecs[3] = '{8'h01, 1'b0, 8'h01, 9, 25};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 9, 25};
    vecs[5] = '{8'h00, 1'b0, 8'h00, 9, 25};

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1;
    chk("reset_bc1", {bo1, bv1, by1, dn1, cs1}, '0);
    chk("reset_bc3", {bo3, bv3, by3, dn3, cs3}, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_busy_done", {by1, dn1, by3, dn3}, '0);
    end

    // Reset during cycle 4 of a frame aborts it with no done pulse.
    @(negedge clk);
    #2 send = 1'b1; data_in = 8'hFF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      send = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("abort_bit_out", {bo1, bo3}, '0);
    chk("abort_all_bc1", {bo1, bv1, by1, dn1, cs1}, '0);
    chk("abort_all_bc3", {bo3, bv3, by3, dn3, cs3}, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("no_done_after_abort", {dn1, dn3}, '0);
    end

    foreach (vecs[i]) run_frame(vecs[i]);

    // Back-to-back frames with send held high.
    dcnt = 0; dfirst = -1; dsecond = -1;
    @(negedge clk);
    #2 send = 1'b1; data_in = 8'h0F;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (dn1) begin
        dcnt++;
        if (dfirst < 0) dfirst = c;
        else if (dsecond < 0) dsecond = c;
      end
      if (c == 9 || c == 10) chk("gap_bit_out", bo1, 1'b0);
      if (c == 10) chk("gap_idle_busy", by1, 1'b0);
      if (c == 11) chk("b2b_reload", {by1, cs1}, {1'b1, 8'h0F});
    end
    #2 send = 1'b0;
    chk("b2b_done_count", dcnt, 4);
    chk("b2b_first_done", dfirst, 9);
    chk("b2b_second_done", dsecond, 19);
    repeat (30) @(negedge clk);

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      #2;
      send    = 1'($urandom_range(0, 1));
      data_in = W'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b1;
        #1;
        chk("rand_reset", {bo1, bv1, by1, dn1, cs1, bo3, bv3, by3, dn3, cs3}, '0);
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    #2 send = 1'b0;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
